i2s_rx: RTL and testbench
=========================

# i2s_rx

Mono I2S capture stage for the audio effect chain. It deserialises the codec ADC stream, with bit clock, LR clock and data all sampled as ordinary inputs in the system clock domain. It emits one signed 16-bit left-channel sample per audio frame as a single-cycle valid pulse. It sits directly upstream of the tremolo stage and drives that stage's `i_data` and `i_valid`.

## Interface
- `DATA_W`, default 16: sample width in bits. Also the number of serial bits captured per frame.
- `SYNC_STAGES`, default 2: flops in each input synchroniser. Minimum 2.
- `i_clk`, input, 1: system clock. Must be at least 4× the BCLK frequency.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_enable`, input, 1: capture enable. Level-sensitive.
- `i_bclk`, input, 1: codec bit clock. Asynchronous.
- `i_lrc`, input, 1: codec ADC LR clock. Low selects the left channel. Asynchronous.
- `i_adcdat`, input, 1: codec serial data, MSB first. Asynchronous.
- `o_data`, output signed, DATA_W: last captured left sample.
- `o_valid`, output, 1: one-cycle pulse when `o_data` updates.
- `o_frame_err`, output, 1: one-cycle pulse when a frame is truncated.

## Operation
- **Synchronisers.** `i_bclk`, `i_lrc` and `i_adcdat` each pass through `SYNC_STAGES` flops.
- **Edge detection.** An extra flop on the synchronised BCLK and LRC produces:
  - `bclk_rise`: synchronised BCLK rising edge.
  - `lrc_fall`: synchronised LRC falling edge.
  - `lrc_rise`: synchronised LRC rising edge.
- **Data sampling.** Data is sampled from the synchronised `adcdat` in the cycle `bclk_rise` is seen.
- **States:**
  - IDLE
    - Stays here while `i_enable` = 0.
    - Goes to WAIT_L when `i_enable` = 1.
  - WAIT_L
    - Goes to SKIP on `lrc_fall`.
    - Capture never starts mid-frame.
  - SKIP
    - I2S one-bit delay: the first `bclk_rise` after `lrc_fall` is ignored.
    - Goes to SHIFT with bit counter = 0.
  - SHIFT
    - On each `bclk_rise`: shift register ← {shift[DATA_W-2:0], adcdat}, and the counter increments.
    - When the counter reaches DATA_W-1 on a `bclk_rise`, the DATA_W-th bit is taken and the state goes to DONE.
    - If `lrc_rise` arrives before DATA_W bits: `o_frame_err` pulses, no `o_valid` is produced, and the state goes to WAIT_L.
  - DONE
    - Lasts one cycle.
    - `o_data` ← shift register and `o_valid` = 1.
    - Goes to WAIT_L. The right half-frame is ignored, and the next `lrc_fall` restarts capture.
- **Enable.** `i_enable` = 0 in any state forces IDLE on the next cycle. A partial frame is discarded with no `o_valid` and no `o_frame_err`. `o_data` keeps its last value.
- **Simultaneous events.** If `bclk_rise` and `lrc_rise` occur in the same cycle in SHIFT, `lrc_rise` wins and the cycle counts as a frame error. The exception is when that `bclk_rise` completes bit DATA_W; then the sample is delivered.
- **Wrap.** The counter never wraps. It is reset to 0 on every entry to SKIP.
- **Data format.** The shift register is loaded as-is, in two's complement. There is no sign extension, scaling or rounding.

## Timing
- **Reset values:** `o_data` = 0, `o_valid` = 0, `o_frame_err` = 0, state = IDLE, synchroniser and edge flops = 0, counter = 0.
- **Input latency.** A pin edge reaches edge detection after `SYNC_STAGES` + 1 cycles.
- **Output latency.** `o_valid` is asserted in the cycle after the one in which the final `bclk_rise` is detected.
- **Output timing.** `o_data` changes in the same cycle `o_valid` is high and holds until the next `o_valid`.
- **Throughput.** At most one `o_valid` per LRC period. `o_valid` is never high on two consecutive cycles.
- **Downstream interface.** There is no backpressure. The downstream stage must accept a sample every cycle `o_valid` = 1.

## Structure
- **Shared package `audio_pkg`** holds:
  - the `AUDIO_W` = 16 constant, used as the `DATA_W` default;
  - the `i2s_state_t` enum {IDLE, WAIT_L, SKIP, SHIFT, DONE}.
- **Sub-module `sync_edge`** holds one synchroniser chain plus an edge-detect flop, with outputs `o_level`, `o_rise` and `o_fall`.
  - Instantiated 3×: BCLK, LRC and ADCDAT.
  - The ADCDAT instance uses `o_level` only.
- The top level contains the FSM, shift register and counter.

## Test plan
- **Nominal frame.** Reset, `i_enable` = 1, BCLK = `i_clk`/8, one left frame carrying 0x8001 → exactly one `o_valid`, with `o_data` = -32767, (SYNC_STAGES + 2) cycles after the 16th BCLK rising edge.
- **Mid-frame start.** Assert `i_enable` while LRC is already low and 5 bits have already been sent → no `o_valid` for that frame. The next frame carrying 0x1234 gives `o_data` = 0x1234.
- **Truncated frame.** Raise LRC after 10 bits → one `o_frame_err` pulse, no `o_valid`, `o_data` unchanged. The following full frame carrying 0x7FFF is delivered.
- **Disable mid-frame.** Drop `i_enable` at bit 8 → no `o_valid`, no `o_frame_err`, state = IDLE the next cycle. Re-enable, and the next full frame is captured.
- **Asynchronous reset mid-SHIFT.** Pulse `i_rst_n` low at bit 12 → all outputs are 0 immediately. The next complete frame captures correctly.
- **Back-to-back frames.** 100 frames with random 16-bit values and random `i_clk` phase offsets → 100 `o_valid` pulses, every sample matches, none on consecutive cycles, and the right-channel bits are never captured.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-chain definitions: native sample width and the I2S capture state set.
package audio_pkg;

    localparam int AUDIO_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_L = 3'd1,
        SKIP   = 3'd2,
        SHIFT  = 3'd3,
        DONE   = 3'd4
    } i2s_state_t;

endpackage

// File: rtl/i2s_rx_if.sv
// Sample bus from the I2S capture stage to the downstream effect stage.
interface i2s_rx_if
    import audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_W
) ();

    logic signed [DATA_W-1:0] o_data;
    logic                     o_valid;
    logic                     o_frame_err;

    modport master (output o_data, output o_valid, output o_frame_err);
    modport slave  (input  o_data, input  o_valid, input  o_frame_err);

endinterface

// File: rtl/i2s_rx_sync_edge.sv
// Synchroniser chain for one asynchronous pin plus a registered edge detector.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Level and edge flags are registered together so they stay cycle-aligned
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_d};
            o_level <= sync_q[SYNC_STAGES-1];
            o_rise  <= sync_q[SYNC_STAGES-1] & ~o_level;
            o_fall  <= ~sync_q[SYNC_STAGES-1] & o_level;
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// Mono I2S receiver: captures the left half-frame of the codec ADC stream as one signed sample.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int DATA_W      = AUDIO_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_enable,
    input  logic     i_bclk,
    input  logic     i_lrc,
    input  logic     i_adcdat,
    i2s_rx_if.master smp
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_WAIT_L = WAIT_L;
    localparam logic [2:0] S_SKIP   = SKIP;
    localparam logic [2:0] S_SHIFT  = SHIFT;
    localparam logic [2:0] S_DONE   = DONE;

    logic bclk_rise, bclk_lvl_unused, bclk_fall_unused;
    logic lrc_rise, lrc_fall, lrc_lvl_unused;
    logic adc_lvl, adc_rise_unused, adc_fall_unused;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shift_p0;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_bclk),
        .o_level(bclk_lvl_unused),
        .o_rise (bclk_rise),
        .o_fall (bclk_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrc (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_lrc),
        .o_level(lrc_lvl_unused),
        .o_rise (lrc_rise),
        .o_fall (lrc_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_adc (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_adcdat),
        .o_level(adc_lvl),
        .o_rise (adc_rise_unused),
        .o_fall (adc_fall_unused)
    );

    // Serial capture stage: the shift register holds data only, so it needs no reset
    always_ff @(posedge i_clk) begin
        if (state == S_SHIFT && bclk_rise) begin
            shift_p0 <= {shift_p0[DATA_W-2:0], adc_lvl};
        end
    end

    // Frame control and output stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            smp.o_data      <= '0;
            smp.o_valid     <= 1'b0;
            smp.o_frame_err <= 1'b0;
        end else begin
            smp.o_valid     <= 1'b0;
            smp.o_frame_err <= 1'b0;
            if (!i_enable) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: state <= S_WAIT_L;
                    S_WAIT_L: begin
                        if (lrc_fall) begin
                            state <= S_SKIP;
                            cnt   <= '0;
                        end
                    end
                    // First BCLK after the LRC edge carries the previous word's LSB
                    S_SKIP: begin
                        if (bclk_rise) state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        // A completing last bit beats a coincident LRC edge
                        if (bclk_rise && cnt == CNT_LAST) begin
                            state       <= S_DONE;
                            smp.o_valid <= 1'b1;
                            smp.o_data  <= {shift_p0[DATA_W-2:0], adc_lvl};
                        end else if (lrc_rise) begin
                            state           <= S_WAIT_L;
                            smp.o_frame_err <= 1'b1;
                        end else if (bclk_rise) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DONE:  state <= S_WAIT_L;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed plus randomized bench for i2s_rx against a frame-level reference model.
module tb_i2s_rx;
    import audio_pkg::*;

    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LSLOTS      = 20;
    localparam int RSLOTS      = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic bclk = 1'b0;
    logic lrc = 1'b1;
    logic adcdat = 1'b0;

    always #5 clk = ~clk;

    i2s_rx_if #(.DATA_W(DATA_W)) smp ();

    i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_enable(enable),
        .i_bclk  (bclk),
        .i_lrc   (lrc),
        .i_adcdat(adcdat),
        .smp     (smp)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int nvalid = 0;
    int nerr = 0;
    int last_vld_cyc = 0;
    logic prev_vld = 1'b0;
    logic [15:0] got_q[$];
    logic [2:0] st_idle = IDLE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling clock edge
    always @(negedge clk) begin
        if (smp.o_valid === 1'b1) begin
            nvalid++;
            got_q.push_back(smp.o_data);
            last_vld_cyc = cyc;
            chk("valid_gap", {31'b0, prev_vld}, 32'd0);
        end
        if (smp.o_frame_err === 1'b1) nerr++;
        prev_vld = (smp.o_valid === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One LRC period: left half carries nbits of word MSB-first after the one-slot delay
    task automatic send_frame(input logic [15:0] word, input int nbits,
                              input int en_slot, input int dis_slot, input int rst_slot);
        int nl;
        nl = (nbits < DATA_W) ? nbits + 1 : LSLOTS;
        for (int s = 0; s < nl; s++) begin
            logic b;
            if (s >= 1 && s <= nbits) b = word[DATA_W-s];
            else b = 1'($urandom_range(0, 1));
            bclk = 1'b0;
            lrc = 1'b0;
            adcdat = b;
            if (s == en_slot) enable = 1'b1;
            if (s == dis_slot) enable = 1'b0;
            if (s == rst_slot) begin
                rst_n = 1'b0;
                #1;
                chk("rst_data", {16'h0, smp.o_data}, 32'd0);
                chk("rst_valid", {31'b0, smp.o_valid}, 32'd0);
                chk("rst_err", {31'b0, smp.o_frame_err}, 32'd0);
                chk("rst_state", {29'b0, dut.state}, {29'b0, st_idle});
            end
            tick(1);
            if (s == dis_slot) chk("dis_state", {29'b0, dut.state}, {29'b0, st_idle});
            if (s == rst_slot) rst_n = 1'b1;
            tick(3);
            bclk = 1'b1;
            if (s == nbits) rise_cyc = cyc;
            tick(4);
        end
        for (int s = 0; s < RSLOTS; s++) begin
            bclk = 1'b0;
            lrc = 1'b1;
            adcdat = 1'($urandom_range(0, 1));
            tick(4);
            bclk = 1'b1;
            tick(4);
        end
    endtask

    task automatic expect_frame(input string tag, input int v0, input int e0,
                                input int want_v, input int want_e, input logic [15:0] want_d);
        chk({tag, "_nvalid"}, nvalid - v0, want_v);
        chk({tag, "_nerr"}, nerr - e0, want_e);
        if (want_v == 1 && got_q.size() > 0) chk({tag, "_sample"}, {16'h0, got_q.pop_front()}, {16'h0, want_d});
        chk({tag, "_hold"}, {16'h0, smp.o_data}, {16'h0, want_d});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v0, e0, vb;
        logic [15:0] w;

        tick(1);
        chk("reset_data", {16'h0, smp.o_data}, 32'd0);
        chk("reset_valid", {31'b0, smp.o_valid}, 32'd0);
        chk("reset_err", {31'b0, smp.o_frame_err}, 32'd0);
        chk("reset_state", {29'b0, dut.state}, {29'b0, st_idle});
        tick(3);
        rst_n = 1'b1;
        tick(2);
        enable = 1'b1;
        tick(3);

        // Nominal frame
        v0 = nvalid; e0 = nerr;
        send_frame(16'h8001, 16, -1, -1, -1);
        expect_frame("nominal", v0, e0, 1, 0, 16'h8001);
        chk("latency", last_vld_cyc - rise_cyc, SYNC_STAGES + 2);
        chk("signed_value", 32'(smp.o_data), 32'(-32767));

        // Enable arrives after 5 bits of a frame already in progress
        enable = 1'b0;
        tick(2);
        chk("idle_when_off", {29'b0, dut.state}, {29'b0, st_idle});
        v0 = nvalid; e0 = nerr;
        send_frame(16'($urandom), 16, 6, -1, -1);
        expect_frame("midstart", v0, e0, 0, 0, 16'h8001);
        v0 = nvalid; e0 = nerr;
        send_frame(16'h1234, 16, -1, -1, -1);
        expect_frame("after_mid", v0, e0, 1, 0, 16'h1234);

        // Truncated frame
        v0 = nvalid; e0 = nerr;
        send_frame(16'($urandom), 10, -1, -1, -1);
        expect_frame("trunc", v0, e0, 0, 1, 16'h1234);
        v0 = nvalid; e0 = nerr;
        send_frame(16'h7FFF, 16, -1, -1, -1);
        expect_frame("after_trunc", v0, e0, 1, 0, 16'h7FFF);

        // Disable mid-frame
        v0 = nvalid; e0 = nerr;
        send_frame(16'($urandom), 16, -1, 8, -1);
        expect_frame("disable", v0, e0, 0, 0, 16'h7FFF);
        enable = 1'b1;
        tick(2);
        w = 16'($urandom);
        v0 = nvalid; e0 = nerr;
        send_frame(w, 16, -1, -1, -1);
        expect_frame("after_dis", v0, e0, 1, 0, w);

        // Asynchronous reset mid-frame
        v0 = nvalid; e0 = nerr;
        send_frame(16'($urandom), 16, -1, -1, 12);
        expect_frame("reset_mid", v0, e0, 0, 0, 16'h0000);
        w = 16'($urandom);
        v0 = nvalid; e0 = nerr;
        send_frame(w, 16, -1, -1, -1);
        expect_frame("after_rst", v0, e0, 1, 0, w);

        // Back-to-back random frames with random phase
        vb = nvalid; e0 = nerr;
        for (int f = 0; f < 100; f++) begin
            w = 16'($urandom);
            tick($urandom_range(0, 3));
            v0 = nvalid;
            send_frame(w, 16, -1, -1, -1);
            expect_frame("b2b", v0, nerr, 1, 0, w);
        end
        chk("b2b_total", nvalid - vb, 32'd100);
        chk("b2b_no_err", nerr - e0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
